// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter with round-robin arbitration.
// A grant stays locked for the whole of a master's CYC.
// A bus watchdog ends stalled strobes with ERR.
module wb_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   // master 0
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_stb_i,
   input  logic            m0_cyc_i,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   // master 1
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_stb_i,
   input  logic            m1_cyc_i,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   // shared slave side
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_stb_o,
   output logic            s_cyc_o,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic [1:0]      gnt_o
);

   // Counter only needs to reach TIMEOUT-1.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

   state_e          state_q, state_d;
   logic            last_q;   // 1: master 1 was granted most recently
   logic [CW-1:0]   wd_cnt_q;
   logic [1:0]      gnt_q;
   logic            wd_err;

   assign gnt_o = gnt_q;

   // Next-state: round-robin from idle, direct handover when the owner releases.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? StGnt0 : StGnt1;
            end else if (m0_cyc_i) begin
               state_d = StGnt0;
            end else if (m1_cyc_i) begin
               state_d = StGnt1;
            end
         end
         StGnt0: begin
            if (!m0_cyc_i) state_d = m1_cyc_i ? StGnt1 : StIdle;
         end
         StGnt1: begin
            if (!m1_cyc_i) state_d = m0_cyc_i ? StGnt0 : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Watchdog fires on the TIMEOUT-th unanswered strobe cycle; a coincident ack or err wins.
   always_comb begin
      wd_err = (TIMEOUT != 0) && s_stb_o && !s_ack_i && !s_err_i && (wd_cnt_q == WD_LAST);
   end

   // State, registered grant, round-robin history and watchdog counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         gnt_q    <= 2'b00;
         last_q   <= 1'b1;
         wd_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= {state_d == StGnt1, state_d == StGnt0};
         if (state_d != state_q) begin
            if (state_d == StGnt0) last_q <= 1'b0;
            if (state_d == StGnt1) last_q <= 1'b1;
         end
         if (state_d != state_q || !s_stb_o || s_ack_i || s_err_i || wd_err) begin
            wd_cnt_q <= '0;
         end else if (wd_cnt_q != WD_LAST) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
         end
      end
   end

   // Forward the granted master to the slave side; all zero when idle.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      unique case (gnt_q)
         2'b01: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_cyc_i & m0_stb_i;
         end
         2'b10: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_cyc_i & m1_stb_i;
         end
         default: ;
      endcase
   end

   // Return path; terminations are suppressed while reset is asserted.
   always_comb begin
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      m0_ack_o = s_ack_i & gnt_q[0] & ~reset;
      m1_ack_o = s_ack_i & gnt_q[1] & ~reset;
      m0_err_o = (s_err_i | wd_err) & gnt_q[0] & ~reset;
      m1_err_o = (s_err_i | wd_err) & gnt_q[1] & ~reset;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (watchdog set to 4 cycles).
module tb_wb_arbiter;

   localparam logic [31:0] D0 = 32'hC0DE_0000;
   localparam logic [31:0] D1 = 32'hF00D_0000;
   localparam logic [3:0]  S0 = 4'hF;
   localparam logic [3:0]  S1 = 4'h3;

   logic        clk, reset;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
   logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
   logic        m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
   logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i;
   logic [1:0]  gnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .gnt_o(gnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row per clock: inputs applied, outputs expected before the next edge.
   typedef struct {
      logic [3:0]  mreq;  // {c0, s0, c1, s1}
      logic [31:0] a0, a1;
      logic [2:0]  ctl;   // {we, s_ack, s_err}
      logic [31:0] sdat;
      logic [1:0]  gnt;
      logic [31:0] sadr;
      logic [1:0]  sbus;  // {s_cyc, s_stb}
      logic [3:0]  ret;   // {ack0, ack1, err0, err1}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic [3:0] mreq, input logic [31:0] a0, a1,
                              input logic [2:0] ctl, input logic [31:0] sdat,
                              input logic [1:0] gnt, input logic [31:0] sadr,
                              input logic [1:0] sbus, input logic [3:0] ret);
      vec_t r;
      r.mreq = mreq; r.a0 = a0; r.a1 = a1; r.ctl = ctl; r.sdat = sdat;
      r.gnt = gnt; r.sadr = sadr; r.sbus = sbus; r.ret = ret;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = 0; m0_we_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_adr_i = 0; m1_we_i = 0;
      s_ack_i = 0; s_err_i = 0; s_dat_i = 0;
   endtask

   initial begin
      logic [31:0] exp_dat;
      logic [3:0]  exp_sel;

      // Both masters request together out of reset: strict 0,1,0,1, no idle gap.
      vecs.push_back(v(4'b1111, 'h10, 'h20, 3'b100, 'h0,  2'b00, 'h0,  2'b00, 4'b0000));
      vecs.push_back(v(4'b1111, 'h10, 'h20, 3'b110, 'h11, 2'b01, 'h10, 2'b11, 4'b1000));
      vecs.push_back(v(4'b0011, 'h10, 'h20, 3'b100, 'h0,  2'b01, 'h10, 2'b00, 4'b0000));
      vecs.push_back(v(4'b1111, 'h14, 'h20, 3'b110, 'h22, 2'b10, 'h20, 2'b11, 4'b0100));
      vecs.push_back(v(4'b1100, 'h14, 'h20, 3'b100, 'h0,  2'b10, 'h20, 2'b00, 4'b0000));
      vecs.push_back(v(4'b1111, 'h14, 'h24, 3'b110, 'h33, 2'b01, 'h14, 2'b11, 4'b1000));
      vecs.push_back(v(4'b0011, 'h14, 'h24, 3'b100, 'h0,  2'b01, 'h14, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0011, 'h14, 'h24, 3'b110, 'h44, 2'b10, 'h24, 2'b11, 4'b0100));
      vecs.push_back(v(4'b0000, 'h14, 'h24, 3'b100, 'h0,  2'b10, 'h24, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0000, 'h0,  'h0,  3'b000, 'h0,  2'b00, 'h0,  2'b00, 4'b0000));
      // m0 single read, ack on the second strobe cycle.
      vecs.push_back(v(4'b1100, 'h1000, 'h0, 3'b000, 'h0, 2'b00, 'h0,    2'b00, 4'b0000));
      vecs.push_back(v(4'b1100, 'h1000, 'h0, 3'b000, 'h0, 2'b01, 'h1000, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1100, 'h1000, 'h0, 3'b010, 'hDEADBEEF, 2'b01, 'h1000, 2'b11,
                       4'b1000));
      vecs.push_back(v(4'b0000, 'h1000, 'h0, 3'b000, 'h0, 2'b01, 'h1000, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0000, 'h0,    'h0, 3'b000, 'h0, 2'b00, 'h0,    2'b00, 4'b0000));
      // m1 keeps CYC over three strobes while m0 waits.
      vecs.push_back(v(4'b0011, 'h0,   'h200, 3'b000, 'h0,  2'b00, 'h0,   2'b00, 4'b0000));
      vecs.push_back(v(4'b1111, 'h300, 'h200, 3'b010, 'hA0, 2'b10, 'h200, 2'b11, 4'b0100));
      vecs.push_back(v(4'b1110, 'h300, 'h200, 3'b000, 'h0,  2'b10, 'h200, 2'b10, 4'b0000));
      vecs.push_back(v(4'b1111, 'h300, 'h204, 3'b010, 'hA4, 2'b10, 'h204, 2'b11, 4'b0100));
      vecs.push_back(v(4'b1111, 'h300, 'h208, 3'b010, 'hA8, 2'b10, 'h208, 2'b11, 4'b0100));
      vecs.push_back(v(4'b1100, 'h300, 'h208, 3'b000, 'h0,  2'b10, 'h208, 2'b00, 4'b0000));
      vecs.push_back(v(4'b1100, 'h300, 'h0,   3'b010, 'hB0, 2'b01, 'h300, 2'b11, 4'b1000));
      vecs.push_back(v(4'b0000, 'h300, 'h0,   3'b000, 'h0,  2'b01, 'h300, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0000, 'h0,   'h0,   3'b000, 'h0,  2'b00, 'h0,   2'b00, 4'b0000));
      // Watchdog: slave never answers m0, err on the 4th strobe cycle only.
      vecs.push_back(v(4'b1100, 'h400, 'h0,   3'b100, 'h0,  2'b00, 'h0,   2'b00, 4'b0000));
      vecs.push_back(v(4'b1111, 'h400, 'h500, 3'b100, 'h0,  2'b01, 'h400, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1111, 'h400, 'h500, 3'b100, 'h0,  2'b01, 'h400, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1111, 'h400, 'h500, 3'b100, 'h0,  2'b01, 'h400, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1111, 'h400, 'h500, 3'b100, 'h0,  2'b01, 'h400, 2'b11, 4'b0010));
      vecs.push_back(v(4'b1111, 'h400, 'h500, 3'b100, 'h0,  2'b01, 'h400, 2'b11, 4'b0000));
      vecs.push_back(v(4'b0011, 'h400, 'h500, 3'b100, 'h0,  2'b01, 'h400, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0011, 'h0,   'h500, 3'b110, 'h55, 2'b10, 'h500, 2'b11, 4'b0100));
      vecs.push_back(v(4'b0000, 'h0,   'h500, 3'b100, 'h0,  2'b10, 'h500, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0000, 'h0,   'h0,   3'b000, 'h0,  2'b00, 'h0,   2'b00, 4'b0000));
      // Ack coincident with expiry wins; slave err goes only to the owner.
      vecs.push_back(v(4'b1100, 'h600, 'h0,   3'b000, 'h0,  2'b00, 'h0,   2'b00, 4'b0000));
      vecs.push_back(v(4'b1100, 'h600, 'h0,   3'b000, 'h0,  2'b01, 'h600, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1100, 'h600, 'h0,   3'b000, 'h0,  2'b01, 'h600, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1100, 'h600, 'h0,   3'b000, 'h0,  2'b01, 'h600, 2'b11, 4'b0000));
      vecs.push_back(v(4'b1100, 'h600, 'h0,   3'b010, 'h12345678, 2'b01, 'h600, 2'b11,
                       4'b1000));
      vecs.push_back(v(4'b1111, 'h600, 'h700, 3'b001, 'h0,  2'b01, 'h600, 2'b11, 4'b0010));
      vecs.push_back(v(4'b0011, 'h600, 'h700, 3'b000, 'h0,  2'b01, 'h600, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0011, 'h0,   'h700, 3'b001, 'h0,  2'b10, 'h700, 2'b11, 4'b0001));
      vecs.push_back(v(4'b0000, 'h0,   'h700, 3'b000, 'h0,  2'b10, 'h700, 2'b00, 4'b0000));
      vecs.push_back(v(4'b0000, 'h0,   'h0,   3'b000, 'h0,  2'b00, 'h0,   2'b00, 4'b0000));

      m0_dat_i = D0; m1_dat_i = D1; m0_sel_i = S0; m1_sel_i = S1;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("reset gnt", 32'(gnt_o), 32'h0);
      check("reset sbus", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'h0);
      check("reset adr", s_adr_o, 32'h0);
      check("reset ret", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = vecs[i].mreq;
         m0_adr_i = vecs[i].a0;
         m1_adr_i = vecs[i].a1;
         m0_we_i  = vecs[i].ctl[2];
         m1_we_i  = vecs[i].ctl[2];
         s_ack_i  = vecs[i].ctl[1];
         s_err_i  = vecs[i].ctl[0];
         s_dat_i  = vecs[i].sdat;
         #1;
         exp_dat = (vecs[i].gnt == 2'b01) ? D0 : (vecs[i].gnt == 2'b10) ? D1 : 32'h0;
         exp_sel = (vecs[i].gnt == 2'b01) ? S0 : (vecs[i].gnt == 2'b10) ? S1 : 4'h0;
         check($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
         check($sformatf("v%0d s_adr", i), s_adr_o, vecs[i].sadr);
         check($sformatf("v%0d cyc/stb", i), 32'({s_cyc_o, s_stb_o}), 32'(vecs[i].sbus));
         check($sformatf("v%0d ack/err", i), 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}),
               32'(vecs[i].ret));
         check($sformatf("v%0d s_dat", i), s_dat_o, exp_dat);
         check($sformatf("v%0d s_sel", i), 32'(s_sel_o), 32'(exp_sel));
         check($sformatf("v%0d s_we", i), 32'(s_we_o),
               32'(vecs[i].ctl[2] & (vecs[i].gnt != 2'b00)));
         if (vecs[i].ret[3]) check($sformatf("v%0d m0_dat", i), m0_dat_o, vecs[i].sdat);
         if (vecs[i].ret[2]) check($sformatf("v%0d m1_dat", i), m1_dat_o, vecs[i].sdat);
         @(posedge clk);
         #1;
      end

      // Reset in the middle of an m1 strobe with an ack in flight.
      idle_inputs();
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h800;
      @(posedge clk);
      #1;
      check("rst pre gnt", 32'(gnt_o), 32'h2);
      s_ack_i = 1;
      reset   = 1;
      #1;
      check("rst ack blocked", 32'({m1_ack_o, m1_err_o, m0_ack_o}), 32'h0);
      @(posedge clk);
      #1;
      s_ack_i = 0;
      check("rst gnt", 32'(gnt_o), 32'h0);
      check("rst cyc/stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
      reset = 0;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h900;
      #1;
      check("post rst idle", 32'(gnt_o), 32'h0);
      @(posedge clk);
      #1;
      check("post rst m0 first", 32'(gnt_o), 32'h1);
      check("post rst adr", s_adr_o, 32'h900);
      idle_inputs();
      @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master Wishbone classic arbiter that shares the single slave-side bus, the wb_mux address decoder feeding RAM, GPIO, 7-seg, VGA and serial, between two requesters.
- Typical pairing: core data port on master 0 and a DMA/loader engine on master 1.
- Arbitration is round-robin and locked for the duration of a master's CYC.
- A bus watchdog terminates stalled cycles with ERR so no master can hang the fabric.

Parameters:
- AW, 32, address width
- DW, 32, data width; SEL width is DW/8
- TIMEOUT, 255, cycles of unacknowledged STB before ERR is forced; 0 disables the watchdog

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_adr_i, m1_adr_i  in  AW  master addresses
- m0_dat_i, m1_dat_i  in  DW  master write data
- m0_dat_o, m1_dat_o  out  DW  read data returned to masters
- m0_we_i, m1_we_i  in  1  write enables
- m0_sel_i, m1_sel_i  in  DW/8  byte selects
- m0_stb_i, m1_stb_i  in  1  strobes
- m0_cyc_i, m1_cyc_i  in  1  cycle requests
- m0_ack_o, m1_ack_o  out  1  acknowledges
- m0_err_o, m1_err_o  out  1  error terminations
- s_adr_o  out  AW  slave-side address
- s_dat_o  out  DW  slave-side write data
- s_dat_i  in  DW  slave-side read data
- s_we_o  out  1  slave-side write enable
- s_sel_o  out  DW/8  slave-side byte selects
- s_stb_o  out  1  slave-side strobe
- s_cyc_o  out  1  slave-side cycle
- s_ack_i  in  1  slave acknowledge
- s_err_i  in  1  slave error
- gnt_o  out  2  one-hot current grant; 00 when idle

Behaviour:
- Clock and reset are fixed: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state IDLE, gnt_o=00, last-granted=1 so master 0 wins the first tie, watchdog count 0.
  - All s_* outputs 0; m*_ack_o=0, m*_err_o=0.
- States: IDLE, GNT0, GNT1. Transitions evaluated each clk edge.
- IDLE:
  - Only m0_cyc_i high → GNT0; only m1_cyc_i high → GNT1.
  - Both high → grant the master that is not last-granted.
  - Grant visible one cycle after CYC rises (arbitration latency 1).
- GNTn:
  - Held while mn_cyc_i=1, including multiple STB phases within one CYC (locked/RMW sequences are never split).
  - When mn_cyc_i=0: if the other master's cyc is high, go directly to GNT(other); else go to IDLE. This gives zero idle cycles between back-to-back masters.
  - last-granted updates on every entry to GNT0/GNT1.
- Slave-side routing is combinational from the granted master:
  - s_adr_o/s_dat_o/s_we_o/s_sel_o copy the granted master's inputs.
  - s_cyc_o = granted mn_cyc_i; s_stb_o = granted mn_cyc_i & mn_stb_i.
  - In IDLE all s_* outputs are 0.
- Return path:
  - mn_ack_o = s_ack_i & gnt_o[n]; mn_err_o = (s_err_i | wd_err) & gnt_o[n].
  - mn_dat_o = s_dat_i for both masters; valid only with that master's ack.
  - The non-granted master sees ack=0 and err=0 at all times.
- Watchdog (TIMEOUT≠0):
  - Counter increments each cycle s_stb_o=1 & s_ack_i=0 & s_err_i=0.
  - Clears on ack, err, s_stb_o=0, or any grant change.
  - When count==TIMEOUT-1 and still no ack: wd_err=1 for exactly one cycle, then the counter clears.
  - If s_ack_i and the timeout coincide, ack wins and no err is issued.
  - The counter saturates logic-wise; it never wraps to produce a spurious err.
- Grant release:
  - A master dropping CYC while STB is pending is legal; the grant releases and the watchdog clears.
  - A master's CYC falling and rising again in one cycle is treated as release; it must rearbitrate.
- Reset mid-transaction:
  - Next edge forces IDLE and all outputs to reset values.
  - An in-flight slave ack arriving in the reset cycle is not forwarded.
- No combinational path from mn_cyc_i to gnt_o; gnt_o is registered.

Test Plan:
- m0 single read, addr 0x1000, slave acks on 2nd STB cycle, data 0xDEADBEEF → gnt_o=01 one cycle after CYC; m0_ack_o pulses once with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0; gnt_o=00 after CYC falls.
- Both masters raise CYC at the same edge out of reset, each doing one write, then both repeat → grant order 0,1,1,0… no: strictly 0,1,0,1; no idle cycle between handover; s_adr_o tracks the granted master.
- m1 holds CYC across 3 STB phases (0x200, 0x204, 0x208) while m0 requests → m0 waits; all three m1 accesses complete before gnt_o=01.
- TIMEOUT=4, slave never acks m0 write → m0_err_o=1 exactly on the 4th STB cycle for one cycle; m0 drops CYC; m1 is then granted normally.
- s_ack_i coincident with watchdog expiry → ack delivered, no err; separately, s_err_i from slave → routed only to the granted master.
- reset asserted during GNT1 with STB high → next cycle gnt_o=00, s_cyc_o=0, s_stb_o=0; after reset both request → m0 granted first.
